// File: rtl/stack_defs.sv
// -----------------------------------------------------------------------------
// stack_defs
// Shared definitions for the stack-calculator sequencer:
//   - default entry / address widths
//   - one-cycle command codes issued by the button FSM
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package stack_defs;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic [4:0] CMD_IDLE = 5'd0;
    localparam logic [4:0] CMD_PSH  = 5'd1;
    localparam logic [4:0] CMD_POP  = 5'd2;
    localparam logic [4:0] CMD_ADD  = 5'd3;
    localparam logic [4:0] CMD_SUB  = 5'd4;
    localparam logic [4:0] CMD_TOP  = 5'd5;
    localparam logic [4:0] CMD_RST  = 5'd6;
    localparam logic [4:0] CMD_INC  = 5'd7;
    localparam logic [4:0] CMD_DEC  = 5'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_CAP_B,
        ST_WR,
        ST_REF_ADDR,
        ST_REF_CAP
    } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Sequencer for the stack-calculator datapath. Takes one-cycle commands from
// the button FSM, drives a single-port synchronous stack RAM (1-cycle read
// latency), tracks the stack pointer (entry count) and display pointer, and
// keeps a registered copy of mem[DP] for the seven-segment path.
//
// Ports:
//   iClk       system clock
//   iRst       asynchronous active-high reset
//   iCmd       command code, non-zero for one cycle (sampled in IDLE only)
//   iSwData    switch value pushed by PSH, sampled when the command is accepted
//   oMemAddr   RAM address
//   oMemWe     RAM write enable (high only in WR)
//   oMemWData  RAM write data
//   iMemRData  RAM read data, valid the cycle after the address
//   oDispData  registered mem[DP]; 0 when the stack is empty
//   oDp        display pointer
//   oSp        entry count / next free address
//   oEmpty     SP == 0
//   oFull      SP == depth
//   oBusy      high whenever the sequencer is not idle
//   oErr       one-cycle pulse after a rejected command
// -----------------------------------------------------------------------------
module stack_ctrl
    import stack_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [4:0]        iCmd,
    input  logic [DATA_W-1:0] iSwData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWe,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [DATA_W-1:0] oDispData,
    output logic [ADDR_W-1:0] oDp,
    output logic [ADDR_W:0]   oSp,
    output logic              oEmpty,
    output logic              oFull,
    output logic              oBusy,
    output logic              oErr
);

    localparam int            DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W+1)'(2);

    state_t              r_state;
    logic [ADDR_W:0]     r_sp;
    logic [ADDR_W-1:0]   r_dp;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_disp;
    logic [DATA_W-1:0]   r_a;
    logic                r_sub;
    logic                r_push;
    logic                r_err;

    logic [ADDR_W:0]     w_sp_m1;
    logic [ADDR_W:0]     w_sp_m2;
    logic [ADDR_W:0]     w_dp_p1;
    logic                w_empty;
    logic                w_full;
    logic                w_inc_ok;

    assign w_sp_m1  = r_sp - SP_ONE;
    assign w_sp_m2  = r_sp - SP_TWO;
    assign w_dp_p1  = {1'b0, r_dp} + SP_ONE;
    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == SP_FULL);
    // DP + 1 < SP also rejects the empty case, since nothing is below zero
    assign w_inc_ok = (w_dp_p1 < r_sp);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_sp    <= '0;
            r_dp    <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_disp  <= '0;
            r_a     <= '0;
            r_sub   <= 1'b0;
            r_push  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (iCmd)
                        CMD_IDLE: ;
                        CMD_PSH: begin
                            if (w_full) begin
                                r_err <= 1'b1;
                            end else begin
                                r_addr  <= r_sp[ADDR_W-1:0];
                                r_wdata <= iSwData;
                                r_we    <= 1'b1;
                                r_push  <= 1'b1;
                                r_state <= ST_WR;
                            end
                        end
                        CMD_POP: begin
                            if (w_empty) begin
                                r_err <= 1'b1;
                            end else begin
                                r_sp <= w_sp_m1;
                                if (r_sp == SP_ONE) begin
                                    r_dp   <= '0;
                                    r_addr <= '0;
                                    r_disp <= '0;
                                end else begin
                                    r_dp    <= w_sp_m2[ADDR_W-1:0];
                                    r_addr  <= w_sp_m2[ADDR_W-1:0];
                                    r_state <= ST_REF_ADDR;
                                end
                            end
                        end
                        CMD_ADD, CMD_SUB: begin
                            if (r_sp < SP_TWO) begin
                                r_err <= 1'b1;
                            end else begin
                                r_sub   <= (iCmd == CMD_SUB);
                                r_push  <= 1'b0;
                                r_addr  <= w_sp_m1[ADDR_W-1:0];
                                r_state <= ST_RD_A;
                            end
                        end
                        CMD_TOP: begin
                            if (w_empty) begin
                                r_err <= 1'b1;
                            end else begin
                                r_dp    <= w_sp_m1[ADDR_W-1:0];
                                r_addr  <= w_sp_m1[ADDR_W-1:0];
                                r_state <= ST_REF_ADDR;
                            end
                        end
                        CMD_RST: begin
                            r_sp   <= '0;
                            r_dp   <= '0;
                            r_addr <= '0;
                            r_disp <= '0;
                        end
                        CMD_INC: begin
                            if (!w_inc_ok) begin
                                r_err <= 1'b1;
                            end else begin
                                r_dp    <= w_dp_p1[ADDR_W-1:0];
                                r_addr  <= w_dp_p1[ADDR_W-1:0];
                                r_state <= ST_REF_ADDR;
                            end
                        end
                        CMD_DEC: begin
                            if (w_empty || r_dp == '0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_dp    <= r_dp - 1'b1;
                                r_addr  <= r_dp - 1'b1;
                                r_state <= ST_REF_ADDR;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_RD_A: begin
                    r_addr  <= w_sp_m2[ADDR_W-1:0];
                    r_state <= ST_RD_B;
                end
                ST_RD_B: begin
                    r_a     <= iMemRData;
                    r_state <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    // NOS is on iMemRData this cycle; the result is formed from it
                    // directly so the write data is already registered in WR.
                    r_wdata <= r_sub ? (iMemRData - r_a) : (iMemRData + r_a);
                    r_we    <= 1'b1;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    // Both PSH and ADD/SUB leave DP on the entry just written.
                    r_we    <= 1'b0;
                    r_dp    <= r_addr;
                    r_sp    <= r_push ? (r_sp + SP_ONE) : w_sp_m1;
                    r_state <= ST_REF_ADDR;
                end
                ST_REF_ADDR: begin
                    r_state <= ST_REF_CAP;
                end
                ST_REF_CAP: begin
                    r_disp  <= iMemRData;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oMemAddr  = r_addr;
    assign oMemWe    = r_we;
    assign oMemWData = r_wdata;
    assign oDispData = r_disp;
    assign oDp       = r_dp;
    assign oSp       = r_sp;
    assign oEmpty    = w_empty;
    assign oFull     = w_full;
    assign oBusy     = (r_state != ST_IDLE);
    assign oErr      = r_err;

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
// Self-checking bench for stack_ctrl. A behavioural stack RAM sits next to the
// DUT; a stack model (plain arrays and integers) predicts pointers, display
// value, error pulse, busy length and write count for every command.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    cmd;
    logic [DW-1:0] sw;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] disp;
    logic [AW-1:0] dp;
    logic [AW:0]   sp;
    logic          empty;
    logic          full;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iCmd      (cmd),
        .iSwData   (sw),
        .oMemAddr  (mem_addr),
        .oMemWe    (mem_we),
        .oMemWData (mem_wdata),
        .iMemRData (mem_rdata),
        .oDispData (disp),
        .oDp       (dp),
        .oSp       (sp),
        .oEmpty    (empty),
        .oFull     (full),
        .oBusy     (busy),
        .oErr      (err)
    );

    // single-port synchronous RAM, read data one cycle after the address
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // reference stack model
    int m_sp, m_dp, m_disp;
    int m_mem [DEPTH];
    bit m_valid [DEPTH];
    int exp_busy, exp_err, exp_we;
    int obs_busy, obs_err, obs_err2, obs_we;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        m_sp = 0; m_dp = 0; m_disp = 0;
    endtask

    task automatic model_apply(input int c, input int s);
        int a, b;
        exp_err = 0; exp_busy = 0; exp_we = 0;
        case (c)
            1: if (m_sp == DEPTH) exp_err = 1;
               else begin
                   m_mem[m_sp] = s; m_valid[m_sp] = 1'b1;
                   m_dp = m_sp; m_sp = m_sp + 1; m_disp = s;
                   exp_busy = 3; exp_we = 1;
               end
            2: if (m_sp == 0) exp_err = 1;
               else begin
                   m_sp = m_sp - 1;
                   if (m_sp == 0) begin m_dp = 0; m_disp = 0; end
                   else begin m_dp = m_sp - 1; m_disp = m_mem[m_dp]; exp_busy = 2; end
               end
            3, 4: if (m_sp < 2) exp_err = 1;
               else begin
                   a = m_mem[m_sp-1];
                   b = m_mem[m_sp-2];
                   m_mem[m_sp-2] = ((c == 3) ? (b + a) : (b - a)) & 255;
                   m_sp = m_sp - 1; m_dp = m_sp - 1; m_disp = m_mem[m_dp];
                   exp_busy = 6; exp_we = 1;
               end
            5: if (m_sp == 0) exp_err = 1;
               else begin m_dp = m_sp - 1; m_disp = m_mem[m_dp]; exp_busy = 2; end
            6: begin m_sp = 0; m_dp = 0; m_disp = 0; end
            7: if (m_sp == 0 || m_dp >= m_sp - 1) exp_err = 1;
               else begin m_dp = m_dp + 1; m_disp = m_mem[m_dp]; exp_busy = 2; end
            8: if (m_sp == 0 || m_dp == 0) exp_err = 1;
               else begin m_dp = m_dp - 1; m_disp = m_mem[m_dp]; exp_busy = 2; end
            default: ;
        endcase
    endtask

    // issue one command, let it run to IDLE, and record what the DUT did
    task automatic step(input int c, input int s);
        model_apply(c, s);
        @(negedge clk); cmd = 5'(c); sw = 8'(s);
        @(negedge clk); cmd = '0; sw = 8'($urandom);
        obs_err = int'(err); obs_busy = 0; obs_we = 0;
        if (busy !== 1'b1 && mem_we === 1'b1) obs_we++;
        for (int k = 0; k < 20 && busy === 1'b1; k++) begin
            obs_busy++;
            if (mem_we === 1'b1) obs_we++;
            @(negedge clk);
        end
        if (busy === 1'b1) obs_busy = 99;
        @(negedge clk);
        obs_err2 = int'(err);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd = '0; sw = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (sp !== 5'd0)       begin n_bad++; $display("FAIL reset_sp: got %0d want 0", sp); end
        n_cmp++; if (dp !== 4'd0)       begin n_bad++; $display("FAIL reset_dp: got %0d want 0", dp); end
        n_cmp++; if (disp !== 8'h00)    begin n_bad++; $display("FAIL reset_disp: got %0h want 0", disp); end
        n_cmp++; if ({err, mem_we, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: err/we/busy=%b want 000", {err, mem_we, busy}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 12'h000) begin n_bad++; $display("FAIL reset_mem_bus: addr=%0h wdata=%0h want 0", mem_addr, mem_wdata); end
        n_cmp++; if ({empty, full} !== 2'b10) begin n_bad++; $display("FAIL reset_empty_full: got %b want 10", {empty, full}); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_push_add();
        step(1, 8'h05);
        step(1, 8'h03);
        n_cmp++; if (obs_busy !== 3) begin n_bad++; $display("FAIL psh_busy: got %0d cycles want 3", obs_busy); end
        n_cmp++; if ({sp, dp} !== {5'd2, 4'd1}) begin n_bad++; $display("FAIL psh_ptrs: sp=%0d dp=%0d want 2/1", sp, dp); end
        n_cmp++; if (disp !== 8'h03) begin n_bad++; $display("FAIL psh_disp: got %0h want 03", disp); end
        n_cmp++; if ({ram[0], ram[1]} !== 16'h0503) begin n_bad++; $display("FAIL psh_ram: got %0h %0h want 05 03", ram[0], ram[1]); end
        step(3, 0);
        n_cmp++; if (obs_busy !== 6) begin n_bad++; $display("FAIL add_busy: got %0d cycles want 6", obs_busy); end
        n_cmp++; if ({sp, dp} !== {5'd1, 4'd0}) begin n_bad++; $display("FAIL add_ptrs: sp=%0d dp=%0d want 1/0", sp, dp); end
        n_cmp++; if (ram[0] !== 8'h08 || disp !== 8'h08) begin n_bad++; $display("FAIL add_result: ram0=%0h disp=%0h want 08", ram[0], disp); end
        n_cmp++; if (obs_err !== 0 || obs_we !== 1) begin n_bad++; $display("FAIL add_err_we: err=%0d we=%0d want 0/1", obs_err, obs_we); end
    endtask

    task automatic test_sub_wrap();
        step(6, 0);
        n_cmp++; if ({sp, dp, disp} !== 17'd0 || obs_busy !== 0) begin n_bad++; $display("FAIL rst_cmd: sp=%0d dp=%0d disp=%0h busy=%0d want 0", sp, dp, disp, obs_busy); end
        step(1, 8'h03);
        step(1, 8'h05);
        step(4, 0);
        n_cmp++; if (ram[0] !== 8'hFE || disp !== 8'hFE || sp !== 5'd1) begin n_bad++; $display("FAIL sub_wrap: ram0=%0h disp=%0h sp=%0d want FE/FE/1", ram[0], disp, sp); end
        step(1, 8'hFF);
        step(1, 8'h02);
        step(3, 0);
        n_cmp++; if (disp !== 8'h01 || obs_err !== 0) begin n_bad++; $display("FAIL add_wrap: disp=%0h err=%0d want 01/0", disp, obs_err); end
    endtask

    task automatic test_errors();
        step(6, 0);
        step(2, 0);
        n_cmp++; if (obs_err !== 1 || obs_err2 !== 0) begin n_bad++; $display("FAIL pop_empty_err: pulse=%0d after=%0d want 1/0", obs_err, obs_err2); end
        n_cmp++; if ({sp, dp, disp} !== 17'd0 || obs_busy !== 0) begin n_bad++; $display("FAIL pop_empty_state: sp=%0d dp=%0d disp=%0h busy=%0d", sp, dp, disp, obs_busy); end
        for (int i = 0; i < DEPTH; i++) step(1, (i * 7 + 1) & 255);
        n_cmp++; if (full !== 1'b1 || sp !== 5'd16) begin n_bad++; $display("FAIL fill: full=%0d sp=%0d want 1/16", full, sp); end
        step(1, 8'hAA);
        n_cmp++; if (obs_err !== 1 || obs_we !== 0) begin n_bad++; $display("FAIL psh_full: err=%0d we=%0d want 1/0", obs_err, obs_we); end
        n_cmp++; if (ram[15] !== 8'd106 || disp !== 8'd106 || sp !== 5'd16) begin n_bad++; $display("FAIL psh_full_state: ram15=%0d disp=%0d sp=%0d want 106/106/16", ram[15], disp, sp); end
        step(6, 0);
        step(1, 8'h11); step(1, 8'h22); step(1, 8'h33);
        step(8, 0); step(8, 0);
        n_cmp++; if (dp !== 4'd0 || disp !== 8'h11) begin n_bad++; $display("FAIL dec_dec: dp=%0d disp=%0h want 0/11", dp, disp); end
        step(8, 0);
        n_cmp++; if (obs_err !== 1 || dp !== 4'd0) begin n_bad++; $display("FAIL dec_zero: err=%0d dp=%0d want 1/0", obs_err, dp); end
        step(5, 0);
        n_cmp++; if (dp !== 4'd2 || disp !== 8'h33 || obs_busy !== 2) begin n_bad++; $display("FAIL top: dp=%0d disp=%0h busy=%0d want 2/33/2", dp, disp, obs_busy); end
        step(7, 0);
        n_cmp++; if (obs_err !== 1 || dp !== 4'd2) begin n_bad++; $display("FAIL inc_top: err=%0d dp=%0d want 1/2", obs_err, dp); end
    endtask

    task automatic test_drop_busy();
        int k;
        step(6, 0);
        step(1, 10);
        step(1, 20);
        model_apply(3, 0);
        @(negedge clk); cmd = 5'd3;
        @(negedge clk); cmd = 5'd1; sw = 8'h77;
        @(negedge clk); cmd = 5'd6;
        @(negedge clk); cmd = '0;
        k = 0;
        while (busy === 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_timeout: still busy after %0d cycles", k); end
        @(negedge clk);
        n_cmp++; if (sp !== 5'd1 || dp !== 4'd0 || disp !== 8'd30 || ram[0] !== 8'd30) begin n_bad++; $display("FAIL drop_busy: sp=%0d dp=%0d disp=%0d ram0=%0d want 1/0/30/30", sp, dp, disp, ram[0]); end
    endtask

    task automatic test_reset_mid();
        step(6, 0);
        step(1, 8'h40);
        step(1, 8'h41);
        @(negedge clk); cmd = 5'd3;
        @(negedge clk); cmd = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if ({sp, dp, disp} !== 17'd0 || {mem_we, busy, err} !== 3'b000 || mem_addr !== 4'd0) begin n_bad++; $display("FAIL reset_mid: sp=%0d dp=%0d disp=%0h we/busy/err=%b addr=%0d want 0", sp, dp, disp, {mem_we, busy, err}, mem_addr); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++; if (ram[0] !== 8'h40 || ram[1] !== 8'h41) begin n_bad++; $display("FAIL reset_mid_nowrite: ram0=%0h ram1=%0h want 40/41", ram[0], ram[1]); end
    endtask

    task automatic test_random();
        int r, c, bad_ram;
        step(6, 0);
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30)      c = 1;
            else if (r < 45) c = 2;
            else if (r < 55) c = 3;
            else if (r < 63) c = 4;
            else if (r < 70) c = 5;
            else if (r < 80) c = 7;
            else if (r < 90) c = 8;
            else if (r < 93) c = 6;
            else             c = int'($urandom_range(9, 31));
            step(c, int'($urandom_range(0, 255)));
            n_cmp++; if (int'(sp) !== m_sp || int'(dp) !== m_dp) begin n_bad++; $display("FAIL rnd_ptrs[%0d] cmd=%0d: sp=%0d dp=%0d want %0d/%0d", n, c, sp, dp, m_sp, m_dp); end
            n_cmp++; if (int'(disp) !== m_disp) begin n_bad++; $display("FAIL rnd_disp[%0d] cmd=%0d: got %0d want %0d", n, c, disp, m_disp); end
            n_cmp++; if (obs_err !== exp_err || obs_err2 !== 0) begin n_bad++; $display("FAIL rnd_err[%0d] cmd=%0d: pulse=%0d after=%0d want %0d/0", n, c, obs_err, obs_err2, exp_err); end
            n_cmp++; if (obs_busy !== exp_busy || obs_we !== exp_we) begin n_bad++; $display("FAIL rnd_timing[%0d] cmd=%0d: busy=%0d we=%0d want %0d/%0d", n, c, obs_busy, obs_we, exp_busy, exp_we); end
            n_cmp++; if (int'(empty) !== int'(m_sp == 0) || int'(full) !== int'(m_sp == DEPTH)) begin n_bad++; $display("FAIL rnd_flags[%0d]: empty=%0d full=%0d sp_model=%0d", n, empty, full, m_sp); end
            bad_ram = 0;
            for (int i = 0; i < DEPTH; i++) if (m_valid[i] && int'(ram[i]) !== m_mem[i]) bad_ram++;
            n_cmp++; if (bad_ram !== 0) begin n_bad++; $display("FAIL rnd_ram[%0d] cmd=%0d: %0d entries differ", n, c, bad_ram); end
        end
    endtask

    initial begin
        test_reset();
        test_push_add();
        test_sub_wrap();
        test_errors();
        test_drop_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
